// File: rtl/fb_pkg.sv
// Shared geometry, types and scan states for the plot framebuffer.
package fb_pkg;
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_CBITS  = 3;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  typedef logic [7:0]          fb_x_t;
  typedef logic [6:0]          fb_y_t;
  typedef logic [14:0]         fb_addr_t;
  typedef logic [FB_CBITS-1:0] fb_colour_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FLUSH, ST_DONE} fb_scan_state_e;

  // y*160 + x as two shifts and adds, so no multiplier is inferred
  function automatic fb_addr_t fb_addr(input fb_x_t x, input fb_y_t y);
    return fb_addr_t'({y, 7'b0}) + fb_addr_t'({y, 5'b0}) + fb_addr_t'(x);
  endfunction
endpackage

// File: rtl/fb_ram.sv
// Simple dual-port synchronous RAM, read-first on address collision.
module fb_ram #(
  parameter int DEPTH = 19200,
  parameter int DW    = 3,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/plot_framebuffer.sv
// Pixel store for the plot bus with a row-major raster scan-out under start/done.
module plot_framebuffer import fb_pkg::*; #(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int CBITS  = FB_CBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       plot_x,
  input  logic [6:0]       plot_y,
  input  logic [CBITS-1:0] plot_colour,
  input  logic             plot,
  input  logic             scan_start,
  output logic             scan_done,
  output logic [7:0]       scan_x,
  output logic [6:0]       scan_y,
  output logic [CBITS-1:0] scan_colour,
  output logic             scan_valid,
  output logic [15:0]      oob_count
);
  fb_scan_state_e state, state_nxt;
  fb_x_t          cnt_x, rd_x;
  fb_y_t          cnt_y, rd_y;
  logic [1:0]     vld_pipe;
  logic           rd_en, abort, last, in_range, wr_en;
  logic [CBITS-1:0] rd_colour;

  assign in_range = (int'(plot_x) < WIDTH) && (int'(plot_y) < HEIGHT);
  assign wr_en    = plot && in_range;
  assign last     = (int'(cnt_x) == WIDTH - 1) && (int'(cnt_y) == HEIGHT - 1);

  fb_ram #(.DEPTH(WIDTH * HEIGHT), .DW(CBITS), .AW(15)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (fb_addr(plot_x, plot_y)),
    .wdata (plot_colour),
    .re    (rd_en),
    .raddr (fb_addr(cnt_x, cnt_y)),
    .rdata (rd_colour)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE:  if (scan_start) state_nxt = ST_SCAN;
      ST_SCAN:
        if (!scan_start) begin
          state_nxt = ST_IDLE;
          abort     = 1'b1;
        end else begin
          rd_en = 1'b1;
          if (last) state_nxt = ST_FLUSH;
        end
      ST_FLUSH:
        if (!scan_start) begin
          state_nxt = ST_IDLE;
          abort     = 1'b1;
        end else begin
          state_nxt = ST_DONE;
        end
      ST_DONE:  if (!scan_start) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // counter parks at (0,0) outside SCAN so every scan starts at the origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (state != ST_SCAN) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (rd_en) begin
      if (int'(cnt_x) == WIDTH - 1) begin
        cnt_x <= '0;
        cnt_y <= cnt_y + 1'b1;
      end else begin
        cnt_x <= cnt_x + 1'b1;
      end
    end
  end

  // vld_pipe[0] tracks the RAM read stage, vld_pipe[1] the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe    <= '0;
      rd_x        <= '0;
      rd_y        <= '0;
      scan_x      <= '0;
      scan_y      <= '0;
      scan_colour <= '0;
      scan_done   <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_en;
      vld_pipe[1] <= vld_pipe[0] && !abort;
      if (rd_en) begin
        rd_x <= cnt_x;
        rd_y <= cnt_y;
      end
      if (vld_pipe[0]) begin
        scan_x      <= rd_x;
        scan_y      <= rd_y;
        scan_colour <= rd_colour;
      end
      scan_done <= (state == ST_DONE) && scan_start;
    end
  end

  assign scan_valid = vld_pipe[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        oob_count <= '0;
    else if (plot && !in_range && oob_count != 16'hFFFF) oob_count <= oob_count + 1'b1;
  end
endmodule

// File: doc/plot_framebuffer.md
# plot_framebuffer

Pixel store at the far end of the plot interface. It accepts one pixel write per cycle on the `x`/`y`/`colour`/`plot` bus that the drawing engines (screen fill, line, circle) drive. It also runs a raster scan-out that reads the whole 160x120 image back out in row-major order under a start/done handshake. It sits between the drawing engines and any consumer of the finished image: display adapter, checksum unit, or testbench scoreboard.

## Interface
Parameters:
- `WIDTH`, 160, visible columns
- `HEIGHT`, 120, visible rows
- `CBITS`, 3, colour bits per pixel

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `plot_x`  in  8  write column
- `plot_y`  in  7  write row
- `plot_colour`  in  CBITS  write colour
- `plot`  in  1  write strobe; one pixel per cycle while high
- `scan_start`  in  1  scan-out request; held high until `scan_done`
- `scan_done`  out  1  scan-out complete
- `scan_x`  out  8  column of the current scan beat
- `scan_y`  out  7  row of the current scan beat
- `scan_colour`  out  CBITS  stored colour at (`scan_x`,`scan_y`)
- `scan_valid`  out  1  scan beat qualifier
- `oob_count`  out  16  saturating count of dropped out-of-range writes

## Operation
Write path:
- On a `plot`-high edge with `plot_x < WIDTH` and `plot_y < HEIGHT`, store `plot_colour` at address `plot_y*WIDTH + plot_x` (15-bit; computed as `(y<<7)+(y<<5)+x`, no multiplier).
- Out-of-range writes are dropped and increment `oob_count`; the count saturates at 0xFFFF.
- Writes are accepted in every FSM state, including during a scan.

Scan FSM, states IDLE, SCAN, FLUSH, DONE:
- IDLE: `scan_start` high moves to SCAN with the read counter at (0,0).
- SCAN: one read per cycle. The counter advances x-fastest: x wraps 159→0 and y increments. After issuing the read of (159,119), go to FLUSH.
- FLUSH: the last beat drains; go to DONE.
- DONE: `scan_done`=1. It is held while `scan_start` is high. When `scan_start` is sampled low, go to IDLE; `scan_done`=0 the next cycle. `scan_start` may reassert immediately afterwards.
- Abort: `scan_start` low in SCAN or FLUSH returns the FSM to IDLE. Any in-flight beat is suppressed, so `scan_valid`=0 from the next cycle. `scan_done` is never asserted on abort.

Memory:
- Simple dual-port, WIDTH*HEIGHT x CBITS, synchronous read.
- Read-before-write: a same-address write and read in the same cycle returns the old colour.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values: `scan_done`=0, `scan_valid`=0, `scan_x`=0, `scan_y`=0, `scan_colour`=0, `oob_count`=0, FSM=IDLE, read counter=(0,0).
- Reset mid-scan returns to IDLE immediately (asynchronous). No further beats are produced.
- Write-to-readable latency: a write at edge k is visible to a read issued at edge k+1 or later.
- Read latency is 1 cycle. `scan_x`/`scan_y` are registered alongside `scan_colour`, so all three align with `scan_valid`.
- Edge 0 samples `scan_start` high in IDLE. Reads issue on edges 1..19200. `scan_valid`=1 after edges 2..19201, one beat per cycle, no gaps. `scan_done`=1 after edge 19202.
- A `scan_start` that stays high after done does not restart a scan; the consumer must drop it and reassert.

## Structure
- Package `fb_pkg` holds:
  - `FB_WIDTH`, `FB_HEIGHT`, `FB_CBITS`, `FB_DEPTH`=19200
  - typedefs `fb_x_t` (logic [7:0]), `fb_y_t` (logic [6:0]), `fb_addr_t` (logic [14:0]), `fb_colour_t`
  - enum `fb_scan_state_e`
- Sub-module `fb_ram`: parameterised simple dual-port synchronous RAM, read-first, infers block RAM.
- Top level contains the address arithmetic, range check, OOB counter, scan FSM and output registers.

## Test plan
- Fill the screen with colour 3'b101 via 19200 in-range writes, then scan: exactly 19200 `scan_valid` beats, all colour 5, coordinates (0,0),(1,0)…(159,119) in order, then `scan_done`=1 one cycle after the last beat.
- Write (5,7)=3, (159,119)=6 and (0,0)=1 over a filled background of 0, then scan: those three beats carry 3, 6 and 1; all others 0.
- Writes at (160,0), (0,120) and (255,127): memory unchanged on scan, `oob_count`=3. Force 70000 OOB writes: `oob_count`=0xFFFF.
- During a scan, write colour 7 to (10,0) on the same edge its read issues: that beat returns the old colour. A write to (10,1) issued earlier returns 7.
- Drop `scan_start` mid-scan at beat 500: `scan_valid`=0 the next cycle, `scan_done` never rises. A new start rescans from (0,0).
- Assert `rst` mid-scan: all outputs at reset values asynchronously. After release, a full scan completes normally and data written before reset is retained.
